digit_blinker: RTL and testbench
================================

Name: digit_blinker

Overview:
- Generalised display-blink controller for the alarm clock seven-segment driver.
- Produces per-digit enables for N digits from a display mode, a cursor index and a self-timed blink phase.
- Restarts the blink phase on cursor movement or user activity so the edited digit is visible immediately.
- Signals an edit timeout after a programmable number of idle blink periods.
- Sits between the top-level clock/alarm FSM and the digit multiplexer.

Parameters:
- NUM_DIGITS, 4, number of display digits; range 2..8.
- HALF_PERIOD, 25000000, clock cycles per blink half-period (visible or dark).
- TIMEOUT_PERIODS, 10, full blink periods of inactivity in SET mode before timeout pulses.
- CUR_W, $clog2(NUM_DIGITS), cursor index width.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- mode, input, 2, display mode: 00 NORMAL, 01 SET, 10 RING, 11 OFF.
- cursor, input, CUR_W, digit under edit in SET mode; 0 = rightmost digit.
- activity, input, 1, one-cycle pulse on any button press.
- digit_en, output, NUM_DIGITS, 1 = digit lit.
- blink_phase, output, 1, 1 = visible half-period.
- timeout, output, 1, one-cycle pulse when SET mode times out.

Behaviour:
- Reset values:
  - digit_en all ones, blink_phase 1, timeout 0.
  - Half-period counter 0, period counter 0, registered previous mode and cursor 0.
- Blink timer: the counter increments every clk.
  - At HALF_PERIOD-1 it wraps to 0 and toggles blink_phase.
  - Each 0->1 toggle increments the period counter (saturating at TIMEOUT_PERIODS).
- Phase restart: on an activity pulse, a cursor change vs. the registered value, or a mode change:
  - Next cycle the half-period counter is 0, blink_phase is 1 and the period counter is 0.
  - Restart has priority over the wrap in the same cycle.
- digit_en is registered, 1 cycle after its inputs:
  - NORMAL: all ones.
  - SET: all ones except bit [cursor], which equals blink_phase.
  - RING: all bits equal blink_phase.
  - OFF: all zeros.
- Out-of-range cursor (cursor >= NUM_DIGITS) in SET: all digits lit, no blink.
- timeout:
  - One-cycle pulse, only in SET mode, on the cycle the period counter reaches TIMEOUT_PERIODS.
  - Does not pulse again until a restart clears the counter.
  - Never asserted outside SET mode.
  - A restart and a reaching of TIMEOUT_PERIODS in the same cycle: restart wins, no pulse.
- Reset mid-operation: all state returns immediately to reset values, asynchronously; outputs follow.
- Mode changes take effect on digit_en one cycle later; blink_phase restarts visible.

Optional Feature:
- Macro BLINK_COLON_EN.
- Defined:
  - Extra output port colon_en, 1 bit, reset value 1, registered.
  - NORMAL: colon_en = blink_phase (seconds heartbeat).
  - SET: 1.
  - RING: blink_phase.
  - OFF: 0.
- Undefined: port absent, no colon logic.

Decomposition:
- Shared package blink_pkg holds:
  - mode encoding constants MODE_NORMAL/MODE_SET/MODE_RING/MODE_OFF;
  - a typedef for the 2-bit mode;
  - the default HALF_PERIOD value.
- One sub-module, blink_timer: holds the half-period counter, blink_phase, restart input and period counter/timeout.
- The digit_en decode stays in digit_blinker.

Test Plan:
- Reset with HALF_PERIOD=4, NUM_DIGITS=4, mode NORMAL: digit_en=4'b1111 and blink_phase=1 during reset; blink_phase toggles every 4 cycles after release; digit_en stays 1111.
- mode SET, cursor=2: digit_en alternates 1111 / 1011 every 4 cycles.
- Cursor moves 2->0 mid-dark: the next cycle has blink_phase=1 and digit_en=1111 for 4 cycles, then 1110.
- mode RING: digit_en alternates 1111 / 0000.
- mode OFF: digit_en=0000 constant.
- SET with no activity, TIMEOUT_PERIODS=3: exactly one timeout pulse when the third visible-phase start arrives after entry, no further pulses; an activity pulse one cycle before that point suppresses the pulse and restarts the count.
- Assert reset_n low mid-SET while dark: digit_en=1111 and blink_phase=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/blink_pkg.sv
// blink_pkg: mode encoding and timing defaults shared by the digit blinker
package blink_pkg;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_NORMAL = 2'b00;
  localparam mode_t MODE_SET    = 2'b01;
  localparam mode_t MODE_RING   = 2'b10;
  localparam mode_t MODE_OFF    = 2'b11;
  localparam int DEFAULT_HALF_PERIOD = 25_000_000;
endpackage

// File: rtl/blink_timer.sv
// blink_timer: self-timed blink phase with restart, period count and edit timeout
// Ports: clk, reset_n (async active-low), restart_i (forces visible phase, clears counts),
//        set_mode_i (timeout allowed), phase_nxt_o (phase being loaded this cycle),
//        phase_o (1 = visible half-period), timeout_o (one-cycle pulse)
module blink_timer import blink_pkg::*; #(
  parameter int HALF_PERIOD     = DEFAULT_HALF_PERIOD,
  parameter int TIMEOUT_PERIODS = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart_i,
  input  logic set_mode_i,
  output logic phase_nxt_o,
  output logic phase_o,
  output logic timeout_o
);
  localparam int CW = $clog2(HALF_PERIOD + 1);
  localparam int PW = $clog2(TIMEOUT_PERIODS + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] per_q, per_d;
  logic phase_q, phase_d, timeout_q, timeout_d, wrap;
  always_comb begin
    wrap = cnt_q == CW'(HALF_PERIOD - 1);
    cnt_d = (restart_i || wrap) ? '0 : cnt_q + CW'(1);
    phase_d = restart_i | (wrap ? ~phase_q : phase_q);
    // a wrap while dark is the start of a new visible phase, i.e. one full period elapsed
    per_d = restart_i ? '0 :
            (wrap && !phase_q && per_q != PW'(TIMEOUT_PERIODS)) ? per_q + PW'(1) : per_q;
    // pulse only on the transition into saturation so it fires once per idle stretch
    timeout_d = set_mode_i && !restart_i && per_d == PW'(TIMEOUT_PERIODS) &&
                per_q != PW'(TIMEOUT_PERIODS);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      per_q     <= '0;
      phase_q   <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      phase_q   <= phase_d;
      timeout_q <= timeout_d;
    end
  end
  assign phase_nxt_o = phase_d;
  assign phase_o     = phase_q;
  assign timeout_o   = timeout_q;
endmodule

// File: rtl/digit_blinker.sv
// digit_blinker: per-digit blink enables for the seven-segment display
// Ports: clk, reset_n (async active-low), mode (00 NORMAL 01 SET 10 RING 11 OFF),
//        cursor (digit under edit, 0 = rightmost), activity (button pulse),
//        digit_en (1 = lit), blink_phase (1 = visible), timeout (SET idle pulse),
//        colon_en (only when BLINK_COLON_EN is defined)
module digit_blinker import blink_pkg::*; #(
  parameter int NUM_DIGITS      = 4,
  parameter int HALF_PERIOD     = DEFAULT_HALF_PERIOD,
  parameter int TIMEOUT_PERIODS = 10,
  parameter int CUR_W           = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            mode,
  input  logic [CUR_W-1:0]      cursor,
  input  logic                  activity,
`ifdef BLINK_COLON_EN
  output logic                  colon_en,
`endif
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  blink_phase,
  output logic                  timeout
);
  mode_t mode_q;
  logic [CUR_W-1:0] cursor_q;
  logic [NUM_DIGITS-1:0] set_en, digit_en_q, digit_en_d;
  logic restart, phase_nxt;
  assign restart = activity || mode != mode_q || cursor != cursor_q;
  blink_timer #(
    .HALF_PERIOD    (HALF_PERIOD),
    .TIMEOUT_PERIODS(TIMEOUT_PERIODS)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .restart_i  (restart),
    .set_mode_i (mode == MODE_SET),
    .phase_nxt_o(phase_nxt),
    .phase_o    (blink_phase),
    .timeout_o  (timeout)
  );
  // decode against the phase being loaded so digit_en and blink_phase stay aligned;
  // an out-of-range cursor matches no digit, leaving all lit
  always_comb begin
    set_en = '1;
    for (int i = 0; i < NUM_DIGITS; i++) set_en[i] = (32'(cursor) == i) ? phase_nxt : 1'b1;
    digit_en_d = mode == MODE_NORMAL ? '1 :
                 mode == MODE_SET    ? set_en :
                 mode == MODE_RING   ? {NUM_DIGITS{phase_nxt}} : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= MODE_NORMAL;
      cursor_q   <= '0;
      digit_en_q <= '1;
    end else begin
      mode_q     <= mode;
      cursor_q   <= cursor;
      digit_en_q <= digit_en_d;
    end
  end
  assign digit_en = digit_en_q;
`ifdef BLINK_COLON_EN
  logic colon_q, colon_d;
  assign colon_d = mode == MODE_SET ? 1'b1 : mode == MODE_OFF ? 1'b0 : phase_nxt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) colon_q <= 1'b1;
    else colon_q <= colon_d;
  end
  assign colon_en = colon_q;
`endif
endmodule

// File: tb/tb_digit_blinker.sv
// tb_digit_blinker: randomized and directed check of digit_blinker against a time-since-restart model
module tb_digit_blinker;
  localparam int ND = 4;
  localparam int HP = 4;
  localparam int TP = 3;
  logic clk = 0;
  logic reset_n;
  logic [1:0] mode = 0;
  logic [1:0] cursor = 0;
  logic activity = 0;
  logic [ND-1:0] digit_en;
  logic blink_phase, timeout;
`ifdef BLINK_COLON_EN
  logic colon_en;
`endif
  int checks = 0, errors = 0, to_cnt = 0;
  int s = 0;
  logic [1:0] pm = 0, pc = 0;
  logic [ND-1:0] en_exp = '1;
  logic ph_exp = 1, to_exp = 0;

  digit_blinker #(.NUM_DIGITS(ND), .HALF_PERIOD(HP), .TIMEOUT_PERIODS(TP)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .cursor(cursor), .activity(activity),
`ifdef BLINK_COLON_EN
    .colon_en(colon_en),
`endif
    .digit_en(digit_en), .blink_phase(blink_phase), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: everything follows from s = clock edges since the last reset or restart
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s = 0; pm = 0; pc = 0; en_exp = '1; ph_exp = 1; to_exp = 0;
    end else begin
      logic rs;
      rs = activity || mode != pm || cursor != pc;
      s = rs ? 0 : s + 1;
      ph_exp = ((s / HP) % 2) == 0;
      to_exp = !rs && mode == 2'b01 && s == 2 * HP * TP;
      en_exp = mode == 2'b00 ? '1 :
               mode == 2'b10 ? {ND{ph_exp}} :
               mode == 2'b11 ? '0 :
               ((~(ND'(1) << cursor)) | (ND'(ph_exp) << cursor));
      pm = mode; pc = cursor;
    end
  end

  always @(negedge clk) begin
    chk("digit_en", 32'(digit_en), 32'(en_exp));
    chk("blink_phase", 32'(blink_phase), 32'(ph_exp));
    chk("timeout", 32'(timeout), 32'(to_exp));
  end

  always @(posedge clk) begin
    #1;
    if (timeout === 1'b1) to_cnt++;
  end

  initial begin
    int c0;
    reset_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_digit_en", 32'(digit_en), 32'h f);
    chk("rst_phase", 32'(blink_phase), 32'h1);
    chk("rst_timeout", 32'(timeout), 32'h0);
    reset_n = 1;
    repeat (3) @(negedge clk);
    chk("normal_vis", 32'(blink_phase), 32'h1);
    @(negedge clk);
    chk("normal_dark", 32'(blink_phase), 32'h0);
    chk("normal_en", 32'(digit_en), 32'hf);
    mode = 2'b01; cursor = 2;
    @(negedge clk);
    chk("set_vis", 32'(digit_en), 32'hf);
    repeat (4) @(negedge clk);
    chk("set_dark", 32'(digit_en), 32'hb);
    cursor = 0;
    @(negedge clk);
    chk("cur_move_phase", 32'(blink_phase), 32'h1);
    chk("cur_move_en", 32'(digit_en), 32'hf);
    repeat (3) @(negedge clk);
    chk("cur_move_en3", 32'(digit_en), 32'hf);
    @(negedge clk);
    chk("cur_move_dark", 32'(digit_en), 32'he);
    c0 = to_cnt;
    repeat (30) @(negedge clk);
    chk("timeout_once", 32'(to_cnt - c0), 32'h1);
    c0 = to_cnt;
    repeat (20) @(negedge clk);
    chk("timeout_no_repeat", 32'(to_cnt - c0), 32'h0);
    activity = 1;
    @(negedge clk);
    activity = 0;
    repeat (23) @(negedge clk);
    c0 = to_cnt;
    activity = 1;
    @(negedge clk);
    activity = 0;
    repeat (10) @(negedge clk);
    chk("timeout_suppressed", 32'(to_cnt - c0), 32'h0);
    repeat (20) @(negedge clk);
    chk("timeout_after_restart", 32'(to_cnt - c0), 32'h1);
    mode = 2'b10;
    @(negedge clk);
    chk("ring_vis", 32'(digit_en), 32'hf);
    repeat (4) @(negedge clk);
    chk("ring_dark", 32'(digit_en), 32'h0);
    mode = 2'b11;
    @(negedge clk);
    chk("off_en", 32'(digit_en), 32'h0);
    repeat (5) @(negedge clk);
    chk("off_en_hold", 32'(digit_en), 32'h0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) cursor = 2'($urandom_range(0, 3));
      activity = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    activity = 0; mode = 2'b01; cursor = 1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("pre_reset_dark_en", 32'(digit_en), 32'hd);
    chk("pre_reset_dark_phase", 32'(blink_phase), 32'h0);
    #2 reset_n = 0;
    #1;
    chk("async_rst_en", 32'(digit_en), 32'hf);
    chk("async_rst_phase", 32'(blink_phase), 32'h1);
    chk("async_rst_timeout", 32'(timeout), 32'h0);
    @(negedge clk);
    reset_n = 1; mode = 0; cursor = 0;
    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
